lcd_write_engine: RTL and testbench
===================================

# lcd_write_engine

Parametrised HD44780-style LCD write controller for the DE2 board I/O path, replacing software bit-banging of the LCD pins. Software pushes command/data bytes into an internal FIFO; the engine generates RS/data setup, a timed EN pulse, hold and the post-write execution wait in hardware. A raw mode keeps the legacy behaviour, driving pins directly from a 32-bit I/O register. Sits between the processor's LCD I/O register and the top-level `LCD_*` pins.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `T_SETUP`, 4: cycles RS/data stable before EN rises; ≥1.
- `T_EN_HIGH`, 25: cycles EN held high; ≥1.
- `T_HOLD`, 2: cycles RS/data held after EN falls; ≥1.
- `T_CMD_WAIT`, 2000: post-write wait for ordinary commands/data; ≥1.
- `T_CLR_WAIT`, 82000: post-write wait for clear (0x01) and home (0x02, 0x03); ≥ `T_CMD_WAIT`.

- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `mode_i` in 1: 0 = raw, 1 = queued; sampled per Operation.
- `raw_lcd_i` in 32: raw-mode pin image: [7:0] data, [8] RW, [9] RS, [10] EN, [31] ON.
- `wr_valid_i` in 1: write request.
- `wr_ready_o` out 1: FIFO not full.
- `wr_rs_i` in 1: 0 = command, 1 = data.
- `wr_data_i` in 8: byte to write.
- `lcd_on_i` in 1: backlight/power enable in queued mode.
- `lcd_data_o` out 8, `lcd_rw_o` out 1, `lcd_rs_o` out 1, `lcd_en_o` out 1, `lcd_on_o` out 1: pins.
- `busy_o` out 1: FSM not IDLE or FIFO not empty.
- `count_o` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overflow_o` out 1: sticky; set on `wr_valid_i` while full.

## Operation
- FIFO: 9-bit entries {rs, data}; push when `wr_valid_i && wr_ready_o`; write while full is dropped and sets `overflow_o` (cleared only by reset). Pointers wrap modulo `FIFO_DEPTH`.
- Mode register `mode_q` loads `mode_i` only while FSM is IDLE; a change mid-transaction takes effect on return to IDLE.
- Raw mode: all pins registered from `raw_lcd_i`; FSM holds IDLE; pushes still accepted and retained, not drained.
- Queued mode FSM: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
  - IDLE: if FIFO non-empty, pop head, latch {rs, data} onto pins, select wait length, go SETUP.
  - SETUP: EN=0 for `T_SETUP` cycles. PULSE: EN=1 for `T_EN_HIGH`. HOLD: EN=0, data/RS unchanged for `T_HOLD`. WAIT: `T_CLR_WAIT` if rs=0 and data ∈ {0x01,0x02,0x03}, else `T_CMD_WAIT`.
  - `lcd_rw_o`=0 throughout; `lcd_on_o` registered from `lcd_on_i`.
- Single down-counter sized `$clog2(T_CLR_WAIT+1)`, reloaded on each state entry.
- Simultaneous push and pop: both occur; count unchanged. Push to empty FIFO is poppable the next cycle.

## Timing
- Reset values: pins all 0, `wr_ready_o`=1, `busy_o`=0, `count_o`=0, `overflow_o`=0, `mode_q`=0, FSM IDLE, FIFO empty.
- Reset asserted mid-transaction: EN drops to 0 asynchronously; FIFO contents discarded.
- All outputs registered; raw mode latency 1 cycle `raw_lcd_i` → pins.
- Pop cycle t (IDLE): data/RS valid at t+1; EN rises at t+1+`T_SETUP`; EN high exactly `T_EN_HIGH` cycles; next pop no earlier than t+`T_SETUP`+`T_EN_HIGH`+`T_HOLD`+wait+1.
- `count_o`, `wr_ready_o` update the cycle after a push/pop.

## Test plan
- Params DEPTH=4, SETUP=2, EN_HIGH=3, HOLD=1, CMD=5, CLR=20; reset, mode 1, push (1,0x41) → data=0x41, RS=1 one cycle later, EN high 3 cycles starting 2 cycles after, next pop 12 cycles after first.
- Push (0,0x01) then (1,0x42) → wait after clear is 20 cycles; 0x42 pop 27 cycles after 0x01 pop.
- Five pushes in consecutive cycles with FSM busy → `wr_ready_o`=0 after 4th accepted (count 4), 5th dropped, `overflow_o`=1 sticky; exactly 4 bytes written in order.
- Mode 0, `raw_lcd_i`=0x8000_06AB → data=0xAB, RW=0, RS=1, EN=1, ON=1 next cycle; switch mode 0→1 during a queued write → completes current write, change applied at IDLE.
- Assert `rst_ni` low during PULSE → EN=0 immediately, `count_o`=0, `busy_o`=0; after release no stale writes.

Source files
------------

// File: rtl/lcd_write_engine.sv
// lcd_write_engine
// HD44780-style LCD write controller. Command/data bytes are queued in a FIFO
// and written to the panel with hardware-timed RS/data setup, EN pulse, hold
// and post-write execution wait. Raw mode drives the pins straight from a
// 32-bit register image, one cycle after it is presented.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   mode_i               0 = raw, 1 = queued (taken only while idle)
//   raw_lcd_i            raw pin image: [7:0] data, [8] RW, [9] RS, [10] EN, [31] ON
//   wr_valid_i/ready_o   FIFO push handshake; wr_rs_i/wr_data_i are the entry
//   lcd_on_i             panel power/backlight in queued mode
//   lcd_*_o              registered LCD pins
//   busy_o               transaction in flight or FIFO not empty
//   count_o              FIFO occupancy
//   overflow_o           sticky: a write arrived while the FIFO was full
module lcd_write_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int T_SETUP    = 4,
  parameter int T_EN_HIGH  = 25,
  parameter int T_HOLD     = 2,
  parameter int T_CMD_WAIT = 2000,
  parameter int T_CLR_WAIT = 82000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          mode_i,
  input  logic [31:0]                   raw_lcd_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic                          wr_rs_i,
  input  logic [7:0]                    wr_data_i,
  input  logic                          lcd_on_i,
  output logic [7:0]                    lcd_data_o,
  output logic                          lcd_rw_o,
  output logic                          lcd_rs_o,
  output logic                          lcd_en_o,
  output logic                          lcd_on_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(T_CLR_WAIT + 1);

  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN_HIGH - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD_WAIT - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  // FIFO storage and pointers
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;

  // Engine state and registered pins
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          long_q;
  logic          mode_q;
  logic [7:0]    data_q;
  logic          rw_q, rs_q, en_q, on_q;

  logic          push, pop;
  logic [8:0]    head;
  logic          head_long;
  logic [19:0]   unused_raw;

  assign unused_raw = raw_lcd_i[30:11];

  assign wr_ready_o = (count_q != FULL);
  assign push       = wr_valid_i && wr_ready_o;
  // mode_i must agree with the stored mode so that a switch to raw requested
  // while idle never lets a new transaction start with a stale queued mode.
  assign pop        = (state_q == S_IDLE) && mode_q && mode_i && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_long  = !head[8] && ((head[7:0] == 8'h01) || (head[7:0] == 8'h02) ||
                                   (head[7:0] == 8'h03));

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {wr_rs_i, wr_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (wr_valid_i && !wr_ready_o) overflow_q <= 1'b1;
    end
  end

  // Write sequencer: each state reloads the shared down-counter on entry and
  // leaves when it reaches zero, so a state lasts exactly (load + 1) cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      on_q <= lcd_on_i;
      rw_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          mode_q <= mode_i;
          if (!mode_q) begin
            data_q <= raw_lcd_i[7:0];
            rw_q   <= raw_lcd_i[8];
            rs_q   <= raw_lcd_i[9];
            en_q   <= raw_lcd_i[10];
            on_q   <= raw_lcd_i[31];
          end else begin
            en_q <= 1'b0;
            if (pop) begin
              data_q  <= head[7:0];
              rs_q    <= head[8];
              long_q  <= head_long;
              cnt_q   <= LD_SETUP;
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            cnt_q   <= LD_EN;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            cnt_q   <= LD_HOLD;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cnt_q   <= long_q ? LD_CLR : LD_CMD;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else cnt_q <= cnt_q - CW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lcd_data_o = data_q;
  assign lcd_rw_o   = rw_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;
  assign lcd_on_o   = on_q;
  assign busy_o     = (state_q != S_IDLE) || (count_q != '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
module tb_lcd_write_engine;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int E     = 3;
  localparam int H     = 1;
  localparam int CMD   = 5;
  localparam int CLR   = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] raw_lcd = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_rs = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        lcd_on = 1'b0;
  logic [7:0]  lcd_data;
  logic        lcd_rw, lcd_rs, lcd_en, lcd_on_pin;
  logic        busy;
  logic [2:0]  count;
  logic        overflow;

  lcd_write_engine #(
    .FIFO_DEPTH(DEPTH), .T_SETUP(S), .T_EN_HIGH(E), .T_HOLD(H),
    .T_CMD_WAIT(CMD), .T_CLR_WAIT(CLR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode_i), .raw_lcd_i(raw_lcd),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_rs_i(wr_rs),
    .wr_data_i(wr_data), .lcd_on_i(lcd_on), .lcd_data_o(lcd_data),
    .lcd_rw_o(lcd_rw), .lcd_rs_o(lcd_rs), .lcd_en_o(lcd_en),
    .lcd_on_o(lcd_on_pin), .busy_o(busy), .count_o(count),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of accepted entries and a timeline. A write
  // popped at cycle k raises EN at k+S and keeps the engine occupied for
  // S+E+H+wait cycles, after which the next entry may be taken.
  typedef struct {
    logic [8:0] v;
    int         rise;
  } exp_t;

  int         cyc = 0;
  logic [8:0] mq[$];
  exp_t       exp_q[$];
  int         m_busy = 0;
  bit         m_mode = 0;
  bit         m_ovf = 0;
  bit         m_on = 0;
  bit         m_pop_flag = 0;
  logic [8:0] m_pop_val;
  bit         m_ready, m_do_pop, m_mode_old;
  logic [8:0] m_e;

  function automatic int wait_len(input logic [8:0] e);
    return (e[8] == 1'b0 && e[7:0] >= 8'd1 && e[7:0] <= 8'd3) ? CLR : CMD;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_busy = 0;
      m_mode = 0;
      m_ovf = 0;
      m_on = 0;
      m_pop_flag = 0;
    end else begin
      cyc++;
      m_ready = (mq.size() < DEPTH);
      m_mode_old = m_mode;
      m_do_pop = (m_busy == 0) && m_mode && mode_i && (mq.size() > 0);
      m_on = (m_busy == 0 && !m_mode_old) ? raw_lcd[31] : lcd_on;
      m_pop_flag = m_do_pop;
      if (m_busy == 0) m_mode = mode_i;
      if (m_do_pop) begin
        m_e = mq.pop_front();
        m_pop_val = m_e;
        m_busy = S + E + H + wait_len(m_e);
        exp_q.push_back('{m_e, cyc + S});
      end else if (m_busy > 0) begin
        m_busy--;
      end
      if (wr_valid) begin
        if (m_ready) mq.push_back({wr_rs, wr_data});
        else m_ovf = 1;
      end
    end
  end

  // Monitor: compares status every cycle and each observed LCD write
  bit   raw_phase = 1;
  bit   prev_en = 0;
  int   en_len = 0;
  int   obs_writes = 0;
  int   obs_rise[$];
  exp_t ex;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 0;
      en_len = 0;
    end else begin
      chk("count", count, mq.size());
      chk("wr_ready", wr_ready, mq.size() < DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, (m_busy > 0) || (mq.size() > 0));
      chk("lcd_on", lcd_on_pin, m_on);
      if (!raw_phase) begin
        if (m_pop_flag) chk("pins_after_pop", {lcd_rs, lcd_data}, m_pop_val);
        if (lcd_en && !prev_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got rs=%0d data=%0h with nothing expected", lcd_rs, lcd_data);
          end else begin
            ex = exp_q.pop_front();
            chk("write_value", {lcd_rs, lcd_data}, ex.v);
            chk("en_rise_cycle", cyc, ex.rise);
            chk("rw_low", lcd_rw, 0);
          end
          obs_rise.push_back(cyc);
          obs_writes++;
          en_len = 1;
        end else if (lcd_en) begin
          en_len++;
        end else if (prev_en) begin
          chk("en_high_len", en_len, E);
        end
      end
      prev_en = lcd_en;
    end
  end

  task automatic drive(input logic rs, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_rs = rs;
    wr_data = d;
  endtask

  task automatic idle();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (!(mq.size() == 0 && m_busy == 0 && exp_q.size() == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < bound, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_engine_idle(input int bound);
    int n = 0;
    while (!(m_busy == 0 && exp_q.size() == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < bound, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_en_high(input int bound);
    int n = 0;
    while (lcd_en !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("en_timeout", n < bound, 1);
  endtask

  int base;
  int nwr;
  logic [31:0] rv;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_data", lcd_data, 0);
    chk("rst_pins", {lcd_rw, lcd_rs, lcd_en, lcd_on_pin}, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // Raw mode: pins follow raw_lcd_i one cycle later
    @(negedge clk);
    raw_lcd = 32'h8000_06AB;
    @(negedge clk);
    chk("raw_data", lcd_data, 8'hAB);
    chk("raw_rw", lcd_rw, 0);
    chk("raw_rs", lcd_rs, 1);
    chk("raw_en", lcd_en, 1);
    chk("raw_on", lcd_on_pin, 1);
    rv = $urandom;
    raw_lcd = rv;
    @(negedge clk);
    chk("raw_rand", {lcd_on_pin, lcd_en, lcd_rs, lcd_rw, lcd_data}, {rv[31], rv[10], rv[9], rv[8], rv[7:0]});
    raw_lcd = '0;
    repeat (2) @(negedge clk);
    raw_phase = 0;
    lcd_on = 1'b1;
    mode_i = 1'b1;

    // Back-to-back ordinary writes: pops 12 cycles apart
    base = obs_rise.size();
    drive(1'b1, 8'h41);
    drive(1'b1, 8'h43);
    idle();
    wait_drain(500);
    chk("n_writes_cmd", obs_rise.size() - base, 2);
    if (obs_rise.size() >= base + 2) chk("spacing_cmd", obs_rise[base+1] - obs_rise[base], 12);

    // Clear command then data: pops 27 cycles apart
    base = obs_rise.size();
    drive(1'b0, 8'h01);
    drive(1'b1, 8'h42);
    idle();
    wait_drain(500);
    chk("n_writes_clr", obs_rise.size() - base, 2);
    if (obs_rise.size() >= base + 2) chk("spacing_clr", obs_rise[base+1] - obs_rise[base], 27);

    // Overflow: five pushes while the engine is busy
    chk("ovf_before", overflow, 0);
    nwr = obs_writes;
    drive(1'b1, 8'h50);
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'h50 + 8'(i));
    idle();
    chk("ovf_count_full", count, 4);
    chk("ovf_ready_low", wr_ready, 0);
    chk("ovf_flag", overflow, 1);
    wait_drain(1000);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_writes", obs_writes - nwr, 5);

    // Mode change mid-write: current write completes, raw applies at idle
    drive(1'b1, 8'h60);
    idle();
    wait_en_high(100);
    mode_i = 1'b0;
    drive(1'b1, 8'h61);
    idle();
    wait_engine_idle(200);
    chk("mode_retained", count, 1);
    raw_lcd = 32'h0000_0255;
    @(negedge clk);
    chk("mode_raw_data", {lcd_rs, lcd_data}, 9'h155);
    raw_lcd = '0;
    @(negedge clk);
    mode_i = 1'b1;
    wait_drain(500);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_rs = 1'($urandom);
      wr_data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      lcd_on = 1'($urandom);
    end
    idle();
    lcd_on = 1'b1;
    wait_drain(5000);

    // Reset during the EN pulse
    drive(1'b1, 8'h70);
    drive(1'b1, 8'h71);
    drive(1'b0, 8'h02);
    idle();
    wait_en_high(100);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", lcd_en, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_busy", busy, 0);
    nwr = obs_writes;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_stale_writes", obs_writes, nwr);
    chk("post_rst_ovf", overflow, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
